square_dec: RTL and testbench
=============================

// Module: square_dec
// PURPOSE
//  Cassette-input decoder: the receive counterpart of the tape square-wave generator.
//  Measures half-periods of the incoming tape level and classifies each as short or long.
//  A pair of equal half-periods forms one bit: short+short = '1' (one 2x-freq cycle),
//  long+long = '0' (one base-freq cycle). Bits arrive LSB first; 8 bits form a byte.
//  Armed per byte by 'start'; sits between the tape-in pin and the ULA cassette shifter.
// PARAMETERS
//  CNT_W     16        half-period counter width (bits)
//  MIN_HALF  16'd1500  half-periods shorter than this (clk cycles) are glitches, ignored
//  THRESH    16'd7550  short/long split: <THRESH short, >=THRESH long (1.5 nominal short)
//  TIMEOUT   16'd20000 no qualified edge for this many clks while busy -> error
// PORTS
//  clk    in   1  system clock (16 MHz nominal)
//  reset  in   1  asynchronous, active-high reset
//  start  in   1  1-clk pulse: arm decoder for one byte (restarts if already busy)
//  din    in   1  raw tape level, asynchronous to clk
//  dout   out  8  decoded byte, valid while done=1
//  done   out  1  byte complete; level, held until next start or reset
//  err    out  1  framing/timeout error; level, held until next start or reset
//  busy   out  1  high from start until done or err
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE; dout=0, done=0, err=0, busy=0; counters=0;
//    synchroniser flops=0.
//  - din passes through a 2-flop synchroniser, then a 3rd flop for edge detect; edge =
//    s2^s3, rise = s2&~s3. Edge-to-state latency: 3 clk after a din transition.
//  - hp_cnt counts clk since the last qualified edge, saturating at TIMEOUT. Cleared on
//    every qualified edge and on start. Edge with hp_cnt<MIN_HALF: not qualified, ignored
//    (counter keeps running, no classification).
//  - States: IDLE -> SYNC -> HALF1 <-> HALF2 -> IDLE.
//    IDLE : on start -> SYNC; clear done, err, bitcnt, shift reg; busy=1.
//    SYNC : wait for a rising edge (not MIN_HALF-qualified); it sets phase, clears
//           hp_cnt -> HALF1. Falling edges ignored. No timeout in SYNC.
//    HALF1: on qualified edge record c1 = (hp_cnt<THRESH) -> HALF2.
//    HALF2: on qualified edge c2 = (hp_cnt<THRESH). If c2==c1: shift c1 into bit 7 of
//           shift reg (right shift, LSB first), bitcnt++; if bitcnt was 7: dout<=shreg
//           result, done=1, busy=0 -> IDLE; else -> HALF1. If c2!=c1: err=1, busy=0 -> IDLE.
//    HALF1/HALF2: hp_cnt reaching TIMEOUT -> err=1, busy=0 -> IDLE.
//  - done and err are never both 1. dout only updates on the done transition; a failed
//    byte leaves the previous dout intact.
//  - start in any state (incl. same clk as a completing edge) wins: re-arms to SYNC,
//    clears done/err, bitcnt, hp_cnt. start while reset high is ignored.
//  - din activity in IDLE has no effect on outputs.
//  - Polarity: any 2 consecutive qualified edges form one half-pair; no level
//    check beyond the initial rising edge in SYNC.
// TESTING
//  1 start, then din: rise, then 0xA5 LSB first with short=5033/long=10066 clk
//    halves -> done=1, dout=8'hA5, err=0, busy=0 within 3 clk of final edge.
//  2 0x00 then 0xFF back-to-back (start re-pulsed after done) -> dout 8'h00 then 8'hFF.
//  3 insert 200-clk glitch pulse mid-long-half of bit 3 in byte 0x5A -> still 8'h5A.
//  4 bit 2 sent as short half + long half -> err=1, done=0, dout keeps previous byte.
//  5 din stuck after bit 4 -> err=1 exactly TIMEOUT clk after last qualified edge.
//  6 reset asserted mid-bit 5, released, start, send 0x3C -> all outputs 0 during reset,
//    then dout=8'h3C; also start mid-byte re-arms and decodes new byte cleanly.

Source files
------------

// File: rtl/square_dec.sv
// Cassette-input decoder: measures tape half-periods, pairs them into bits
// (short+short = 1, long+long = 0), and assembles one LSB-first byte per start.
module square_dec #(
    parameter int unsigned     CNT_W    = 16,
    parameter logic [CNT_W-1:0] MIN_HALF = 16'd1500,
    parameter logic [CNT_W-1:0] THRESH   = 16'd7550,
    parameter logic [CNT_W-1:0] TIMEOUT  = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       din,
    output logic [7:0] dout,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_HALF1 = 2'd2,
        ST_HALF2 = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       dout_q, dout_d;
    logic             c1_q, c1_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic edge_c, rise_c, qual_c, short_c, tmo_c;

    // Two-flop synchroniser plus one extra stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_c  = s2_q ^ s3_q;
    assign rise_c  = s2_q & ~s3_q;
    assign qual_c  = edge_c && (hp_cnt_q >= MIN_HALF);
    assign short_c = hp_cnt_q < THRESH;
    // Counter is about to reach TIMEOUT on this clock.
    assign tmo_c   = hp_cnt_q >= (TIMEOUT - CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        hp_cnt_d = (hp_cnt_q < TIMEOUT) ? (hp_cnt_q + CNT_W'(1)) : TIMEOUT;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        c1_d     = c1_q;
        done_d   = done_q;
        err_d    = err_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: ;
            ST_SYNC: begin
                if (rise_c) begin
                    hp_cnt_d = '0;
                    state_d  = ST_HALF1;
                end
            end
            ST_HALF1: begin
                if (qual_c) begin
                    c1_d     = short_c;
                    hp_cnt_d = '0;
                    state_d  = ST_HALF2;
                end else if (tmo_c) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HALF2: begin
                if (qual_c) begin
                    hp_cnt_d = '0;
                    if (short_c == c1_q) begin
                        shreg_d  = {c1_q, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            dout_d  = {c1_q, shreg_q[7:1]};
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HALF1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_c) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start pulse overrides whatever the current state decided.
        if (start) begin
            state_d  = ST_SYNC;
            hp_cnt_d = '0;
            bitcnt_d = '0;
            shreg_d  = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hp_cnt_q <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            dout_q   <= '0;
            c1_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hp_cnt_q <= hp_cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            dout_q   <= dout_d;
            c1_q     <= c1_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_square_dec.sv
// Directed bench for square_dec, run with timing constants scaled down by 20
// so the whole sequence stays short.
module tb_square_dec;

    localparam int MIN_HALF = 75;
    localparam int THRESH   = 377;
    localparam int TIMEOUT  = 1000;
    localparam int SHORT_H  = 252;
    localparam int LONG_H   = 503;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout;
    logic       done, err, busy;

    int checks = 0;
    int errors = 0;

    square_dec #(
        .CNT_W   (16),
        .MIN_HALF(16'(MIN_HALF)),
        .THRESH  (16'(THRESH)),
        .TIMEOUT (16'(TIMEOUT))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .din  (din),
        .dout (dout),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic arm();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        din   = 1'b0;
        tick(10);
        din   = 1'b1;
    endtask

    task automatic half(input int n);
        tick(n);
        din = ~din;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            half(b[i] ? SHORT_H : LONG_H);
            half(b[i] ? SHORT_H : LONG_H);
        end
    endtask

    task automatic expect_done(input string tag, input logic [7:0] v);
        tick(2);
        chk({tag, "_done_early"}, 8'(done), 8'd0);
        tick(1);
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_dout"}, dout, v);
        chk({tag, "_err"},  8'(err),  8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        tick(2);
        chk("rst_dout", dout, 8'h00);
        chk("rst_flags", {5'd0, done, err, busy}, 8'd0);
        reset = 1'b0;
        tick(3);

        // Basic byte
        arm();
        chk("armed_busy", 8'(busy), 8'd1);
        send_bits(8'hA5, 8);
        expect_done("a5", 8'hA5);

        // Tape activity while idle must not disturb results
        half(50);
        half(50);
        tick(5);
        chk("idle_dout", dout, 8'hA5);
        chk("idle_done", 8'(done), 8'd1);

        // Back-to-back bytes
        arm();
        chk("rearm_done_clr", 8'(done), 8'd0);
        send_bits(8'h00, 8);
        expect_done("b00", 8'h00);
        arm();
        send_bits(8'hFF, 8);
        expect_done("bff", 8'hFF);

        // Short glitch early in a long half is ignored
        arm();
        send_bits(8'h5A, 2);
        tick(40);
        din = ~din;
        tick(10);
        din = ~din;
        half(LONG_H - 50);
        half(LONG_H);
        send_bits(8'h5A >> 3, 5);
        expect_done("glitch", 8'h5A);

        // Mismatched half pair -> framing error
        arm();
        send_bits(8'hFF, 2);
        half(SHORT_H);
        half(LONG_H);
        tick(3);
        chk("frm_err", 8'(err), 8'd1);
        chk("frm_done", 8'(done), 8'd0);
        chk("frm_busy", 8'(busy), 8'd0);
        chk("frm_dout", dout, 8'h5A);

        // Stuck input -> timeout exactly TIMEOUT clocks after last qualified edge
        arm();
        chk("tmo_err_clr", 8'(err), 8'd0);
        send_bits(8'h1F, 5);
        tick(TIMEOUT + 2);
        chk("tmo_early", 8'(err), 8'd0);
        chk("tmo_busy_early", 8'(busy), 8'd1);
        tick(1);
        chk("tmo_err", 8'(err), 8'd1);
        chk("tmo_done", 8'(done), 8'd0);
        chk("tmo_busy", 8'(busy), 8'd0);
        chk("tmo_dout", dout, 8'h5A);

        // Reset mid-bit, start ignored while reset is high
        arm();
        send_bits(8'h00, 5);
        tick(200);
        reset = 1'b1;
        #1;
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_flags", {5'd0, done, err, busy}, 8'd0);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        chk("rst_start_busy", 8'(busy), 8'd0);
        reset = 1'b0;
        tick(3);
        chk("post_rst_busy", 8'(busy), 8'd0);
        arm();
        send_bits(8'h3C, 8);
        expect_done("b3c", 8'h3C);

        // Start in the middle of a byte re-arms cleanly
        arm();
        send_bits(8'hFF, 3);
        tick(100);
        arm();
        send_bits(8'hC3, 8);
        expect_done("rearm", 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
